// File: rtl/uart_tx_8n1_if.sv
// Byte handshake between a producer and the uart_tx_8n1 transmitter.
// The producer drives tx_data/tx_valid; the transmitter answers with tx_ready.
interface uart_tx_8n1_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8-data-bit asynchronous serial transmitter, LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_8n1 #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  uart_tx_8n1_if.slave  tx_if,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]           STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]       state;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       shift_reg;
  logic             bit_done;
  logic             accept;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign tx_if.tx_ready = (state == ST_IDLE) && ena && !rst;
  assign accept         = tx_if.tx_ready && tx_if.tx_valid;
  assign busy           = (state != ST_IDLE);
  assign bit_done       = (div_cnt == DIV_LAST);

  // tx is loaded with the level of the state being entered, so the pin is a
  // clean flop output that changes exactly on each bit boundary.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every flop samples
    // pre-edge values; blocking assignment would make ordering matter.
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (accept) begin
            state     <= ST_START;
            shift_reg <= tx_if.tx_data;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_if.tx_data;
`endif
          end
        end

        ST_START: begin
          if (bit_done) begin
            div_cnt <= '0;
            state   <= ST_DATA;
            tx      <= shift_reg[0];
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            div_cnt   <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              tx      <= parity_bit;
`else
              state   <= ST_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift_reg[1];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            div_cnt <= '0;
            state   <= ST_STOP;
            tx      <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
`endif

        ST_STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            div_cnt <= '0;
            // bit_cnt is reused to count stop bits
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_8n1.md
Name: uart_tx_8n1

Overview:
- Byte-serial UART transmitter, the transmit end of the serial link whose receive side sits behind the top-level dedicated inputs.
- Accepts bytes over a valid/ready handshake and shifts out an 8-data-bit, no-parity, STOP_BITS-stop-bit asynchronous frame on one output pin, LSB first.
- Instantiated inside the top-level wrapper; `tx` maps to one dedicated output bit.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  block enable; gates acceptance of new bytes.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high while a frame is in flight.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - tx=1, tx_ready=0 during the reset cycle, busy=0.
  - FSM=IDLE; bit counter=0; divider counter=0; shift register=0.
- tx_ready:
  - Combinational: tx_ready = (state==IDLE) && ena && !rst.
- Handshake:
  - Byte accepted on a rising edge where tx_valid && tx_ready.
  - tx_data latched into the shift register on that edge.
  - tx_data and tx_valid are ignored at all other times.
- FSM states and transitions:
  - IDLE: tx=1, busy=0. On accept, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit; shift right after each bit. After 8 bits, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then go to IDLE.
- Latency and frame length:
  - tx falls in the cycle immediately after the accept edge.
  - busy is high from the cycle after accept through the last STOP cycle.
  - Frame occupies exactly (1+8+STOP_BITS)*CLK_DIV cycles.
  - IDLE lasts at least 1 cycle between frames, so back-to-back frames are (10+STOP_BITS-1)*CLK_DIV+1 cycles apart when tx_valid is held high.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0 on each bit boundary.
  - Counter width is $clog2(CLK_DIV); no drift across bits.
- Bit order: LSB first (D0..D7).
- tx is driven from a flop, so there are no combinational glitches.
- ena deasserted in IDLE: no accept, tx stays 1.
- ena deasserted mid-frame: the frame runs to completion; next accept waits for ena=1.
- rst asserted mid-frame: next cycle tx=1, busy=0, state IDLE; the partial frame is abandoned and not resent.
- tx_data changing while busy has no effect on the frame in flight.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 latched data bits (even parity) for CLK_DIV cycles.
  - Frame length becomes (2+8+STOP_BITS)*CLK_DIV.
- Undefined:
  - No PARITY state and no parity logic is synthesised.
  - Behaviour is exactly as above.

Test Plan:
1. Reset behaviour: CLK_DIV=4, STOP_BITS=1; hold rst=1 for 3 cycles, then release with ena=1 -> tx=1, busy=0 throughout reset; tx_ready=1 on the first cycle after release.
2. Single byte 0x55: accept 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy high for 40 cycles; tx_ready returns to 1 on cycle 41.
3. Back-to-back: tx_valid held high with 0xA3 then 0x0F -> both frames correct, LSB first; exactly 1 IDLE cycle between the stop bit of frame 1 and the start bit of frame 2; no byte duplicated or lost.
4. Enable gating: ena=0 with tx_valid=1 for 20 cycles -> tx_ready=0, tx stays 1. Dropping ena mid-frame for 0xFF -> frame still completes in 40 cycles.
5. Reset mid-frame: assert rst during D3 of 0x00 -> tx=1 and busy=0 on the next cycle; a new byte 0x81 is sent cleanly afterwards.
6. Parity build: with UART_TX_PARITY_EN and STOP_BITS=2, send 0x07 -> parity bit=1, two stop bits, frame of 48 cycles. Send 0x03 -> parity bit=0.
